// File: rtl/shoelace_pkg.sv
// Shared types and constants for the shoelace loop checker.
package shoelace_pkg;

   // Run sequencing: launch a toggle, wait for returns, idle gap, repeat.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      GAP    = 2'd3
   } state_t;

   // Depth of the synchroniser on each returned signal.
   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/shoelace_chan.sv
// One loop channel: owns the outgoing toggle and the synchroniser on its return.
// Compares the return against the expected level and keeps the channel's
// pending flag, sticky error flags, return count and last latency.
module shoelace_chan
   import shoelace_pkg::*;
#(
   parameter int   CNT_W  = 16,
   parameter int   LAT_W  = 8,
   parameter logic INVERT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             launch,
   input  logic             chan_en,
   input  logic             in_wait,
   input  logic             in_check,
   input  logic             timeout,
   input  logic [LAT_W-1:0] lat,
   input  logic             from_ext,
   output logic             to_ext,
   output logic             still_pending,
   output logic             complete,
   output logic             err_timeout,
   output logic             err_glitch,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic [LAT_W-1:0] last_lat
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   to_ext_r;
   logic                   en_r;
   logic                   pending_r;
   logic                   err_timeout_r;
   logic                   err_glitch_r;
   logic [CNT_W-1:0]       toggle_cnt_r;
   logic [LAT_W-1:0]       last_lat_r;

   logic                   expected_s;
   logic                   match_s;
   logic                   glitch_s;

   // Compare the synchronised return against the level the chain should settle to.
   always_comb begin
      expected_s    = to_ext_r ^ INVERT;
      match_s       = (sync_r[SYNC_STAGES-1] == expected_s);
      complete      = in_wait & pending_r & match_s;
      still_pending = pending_r & ~match_s;
      glitch_s      = in_check & en_r & ~pending_r & ~match_s;
   end

   // Two-flop synchroniser on the asynchronous return.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], from_ext};
      end
   end

   // Outgoing toggle, enable snapshot and outstanding-return flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_ext_r  <= 1'b0;
         en_r      <= 1'b0;
         pending_r <= 1'b0;
      end else if (launch) begin
         to_ext_r  <= to_ext_r ^ chan_en;
         en_r      <= chan_en;
         pending_r <= chan_en;
      end else if (complete || timeout) begin
         pending_r <= 1'b0;
      end
   end

   // Sticky errors, return count and latency; cleared when a run is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_timeout_r <= 1'b0;
         err_glitch_r  <= 1'b0;
         toggle_cnt_r  <= '0;
         last_lat_r    <= '0;
      end else if (clear) begin
         err_timeout_r <= 1'b0;
         err_glitch_r  <= 1'b0;
         toggle_cnt_r  <= '0;
         last_lat_r    <= '0;
      end else begin
         if (complete) begin
            toggle_cnt_r <= toggle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            last_lat_r   <= lat;
         end
         if (timeout && still_pending) begin
            err_timeout_r <= 1'b1;
         end
         if (glitch_s) begin
            err_glitch_r <= 1'b1;
         end
      end
   end

   assign to_ext      = to_ext_r;
   assign err_timeout = err_timeout_r;
   assign err_glitch  = err_glitch_r;
   assign toggle_cnt  = toggle_cnt_r;
   assign last_lat    = last_lat_r;

endmodule

// File: rtl/shoelace_loop_checker.sv
// Drives NCHAN toggle loops out to the switch-level simulator and checks the
// returns: round-trip latency, timeouts, glitches and per-channel return counts.
module shoelace_loop_checker
   import shoelace_pkg::*;
#(
   parameter int               NCHAN       = 4,
   parameter int               CNT_W       = 16,
   parameter int               LAT_W       = 8,
   parameter int               TIMEOUT     = 64,
   parameter logic [NCHAN-1:0] INVERT_MASK = {NCHAN{1'b1}}
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_launch,
   input  logic [7:0]               gap,
   input  logic [NCHAN-1:0]         chan_en,
   output logic [NCHAN-1:0]         to_ext,
   input  logic [NCHAN-1:0]         from_ext,
   output logic                     busy,
   output logic                     done,
   output logic [NCHAN-1:0]         err_timeout,
   output logic [NCHAN-1:0]         err_glitch,
   output logic [NCHAN*CNT_W-1:0]   toggle_cnt,
   output logic [NCHAN*LAT_W-1:0]   last_lat,
   output logic [LAT_W-1:0]         max_lat
);

   localparam logic [LAT_W-1:0] TIMEOUT_LAT = LAT_W'(TIMEOUT);
   localparam logic [LAT_W-1:0] LAT_ONE     = LAT_W'(1);

   state_t            state_r;
   state_t            next_s;
   logic [CNT_W-1:0]  remaining_r;
   logic [7:0]        gap_r;
   logic [7:0]        gap_cnt_r;
   logic [LAT_W-1:0]  lat_r;
   logic [LAT_W-1:0]  max_lat_r;
   logic              busy_r;
   logic              done_r;

   logic              accept_s;
   logic              launch_s;
   logic              in_wait_s;
   logic              in_check_s;
   logic              timeout_s;
   logic              gap_done_s;
   logic              done_next_s;
   logic [NCHAN-1:0]  complete_s;
   logic [NCHAN-1:0]  still_pending_s;

   // Per-channel loop logic.
   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      shoelace_chan #(
         .CNT_W  (CNT_W),
         .LAT_W  (LAT_W),
         .INVERT (INVERT_MASK[i])
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .clear         (accept_s),
         .launch        (launch_s),
         .chan_en       (chan_en[i]),
         .in_wait       (in_wait_s),
         .in_check      (in_check_s),
         .timeout       (timeout_s),
         .lat           (lat_r),
         .from_ext      (from_ext[i]),
         .to_ext        (to_ext[i]),
         .still_pending (still_pending_s[i]),
         .complete      (complete_s[i]),
         .err_timeout   (err_timeout[i]),
         .err_glitch    (err_glitch[i]),
         .toggle_cnt    (toggle_cnt[i*CNT_W +: CNT_W]),
         .last_lat      (last_lat[i*LAT_W +: LAT_W])
      );
   end

   // Next-state and per-cycle control strobes for the run sequencer.
   always_comb begin
      next_s      = state_r;
      accept_s    = 1'b0;
      launch_s    = 1'b0;
      in_wait_s   = 1'b0;
      in_check_s  = 1'b0;
      timeout_s   = 1'b0;
      done_next_s = 1'b0;
      gap_done_s  = (({1'b0, gap_cnt_r} + 9'd1) >= {1'b0, gap_r});
      case (state_r)
         IDLE: begin
            if (start) begin
               accept_s = 1'b1;
               if (num_launch == {CNT_W{1'b0}}) begin
                  done_next_s = 1'b1;
                  next_s      = IDLE;
               end else begin
                  next_s = LAUNCH;
               end
            end else begin
               next_s = IDLE;
            end
         end
         LAUNCH: begin
            launch_s = 1'b1;
            next_s   = WAIT;
         end
         WAIT: begin
            in_wait_s  = 1'b1;
            in_check_s = 1'b1;
            if (still_pending_s == {NCHAN{1'b0}}) begin
               next_s = GAP;
            end else if (lat_r == TIMEOUT_LAT) begin
               timeout_s = 1'b1;
               next_s    = GAP;
            end else begin
               next_s = WAIT;
            end
         end
         GAP: begin
            in_check_s = 1'b1;
            if (!gap_done_s) begin
               next_s = GAP;
            end else if (remaining_r != {CNT_W{1'b0}}) begin
               next_s = LAUNCH;
            end else begin
               done_next_s = 1'b1;
               next_s      = IDLE;
            end
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

   // State register with registered busy/done flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         busy_r  <= (next_s != IDLE);
         done_r  <= done_next_s;
      end
   end

   // Run parameters: launches left and the idle gap length, captured on start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining_r <= '0;
         gap_r       <= 8'd0;
      end else if (accept_s) begin
         remaining_r <= num_launch;
         gap_r       <= gap;
      end else if (launch_s) begin
         remaining_r <= remaining_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Gap cycle counter, restarted whenever the sequencer is outside GAP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap_cnt_r <= 8'd0;
      end else if (state_r == GAP && !gap_done_s) begin
         gap_cnt_r <= gap_cnt_r + 8'd1;
      end else begin
         gap_cnt_r <= 8'd0;
      end
   end

   // Latency counter: reads 1 in the first WAIT cycle and saturates at the timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_r <= '0;
      end else if (launch_s) begin
         lat_r <= LAT_ONE;
      end else if (in_wait_s && lat_r != TIMEOUT_LAT) begin
         lat_r <= lat_r + LAT_ONE;
      end
   end

   // Worst latency of the run; all completions in a cycle share the same latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_lat_r <= '0;
      end else if (accept_s) begin
         max_lat_r <= '0;
      end else if ((complete_s != {NCHAN{1'b0}}) && (lat_r > max_lat_r)) begin
         max_lat_r <= lat_r;
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign max_lat = max_lat_r;

endmodule
